inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fifo.sv | 59 +++++
 rtl/inst_fetch.sv | 162 ++++++++++++++++
 tb/tb_inst_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_MISALIGN_CHECK_EN adds the HALT state used for misaligned redirect faults.
package inst_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1
`ifdef FETCH_MISALIGN_CHECK_EN
    , ST_HALT = 2'd2
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] opcode;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous fetch buffer of {pc, opcode} entries with clear and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output fetch_entry_t           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: in-order memory requests, fetch buffer, redirect flush.
// Define FETCH_MISALIGN_CHECK_EN to fault and halt on misaligned redirect targets.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_opcode,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
  output logic        o_misaligned
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic          req_q, req_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ_next;
  logic          acc, rsp, push, pop, clear;
  logic          fifo_full, fifo_empty;
  logic          unused_full;
  logic [31:0]   redir_addr;
  fetch_entry_t  push_entry, head;

  assign acc        = req_q && i_imem_ack;
  assign rsp        = i_imem_rvalid && (inflight_q != '0);
  assign push_entry = '{pc: rsp_pc_q, opcode: i_imem_rdata};
  assign unused_full = fifo_full;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign redir_addr   = i_redirect_addr;
  assign o_misaligned = mis_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_redirect_addr[1:0];
  assign redir_addr      = {i_redirect_addr[31:2], 2'b00};
  assign o_misaligned    = 1'b0;
`endif

  // Next-state: redirect wins over push/pop; stale responses are counted off before keeping data.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(acc) - CW'(rsp);
    stale_d    = stale_q;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d      = mis_q;
`endif
    if (rsp && (stale_q != '0)) begin
      stale_d = stale_q - CW'(1);
    end
    case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (i_redirect) begin
          clear    = 1'b1;
          pc_d     = redir_addr;
          rsp_pc_d = redir_addr;
          stale_d  = inflight_d;
          state_d  = (inflight_d != '0) ? ST_FLUSH : ST_RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (i_redirect_addr[1:0] != 2'b00) begin
            state_d = ST_HALT;
            mis_d   = 1'b1;
          end
`endif
        end else begin
          if (acc) begin
            pc_d = pc_q + 32'd4;
          end
          push = rsp && (stale_q == '0);
          pop  = o_valid && i_ready;
          if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
          end
          if (stale_d == '0) begin
            state_d = ST_RUN;
          end
        end
      end
      default: clear = 1'b1;
    endcase
  end

  // Request only while outstanding requests plus buffered entries leave room.
  always_comb begin
    occ_next = clear ? '0 : (fifo_count + CW'(push) - CW'(pop));
    req_d    = (SW'(inflight_d) + SW'(occ_next)) < SW'(FIFO_DEPTH);
`ifdef FETCH_MISALIGN_CHECK_EN
    if (state_d == ST_HALT) begin
      req_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      req_q      <= 1'b0;
      inflight_q <= '0;
      stale_q    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      req_q      <= req_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q      <= mis_d;
`endif
    end
  end

  inst_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .clear_i (clear),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign o_imem_req  = req_q;
  assign o_imem_addr = pc_q;
  assign o_valid     = !fifo_empty;
  assign o_opcode    = head.opcode;
  assign o_pc        = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: in-order memory model with random latency, sequential-PC
// delivery scoreboard, a cycle table after reset and directed redirect corner cases.
`timescale 1ns/1ps
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int unsigned     DEPTH = 4;
  localparam logic [31:0]     RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imem_req, i_imem_ack, i_imem_rvalid;
  logic [31:0] o_imem_addr, i_imem_rdata;
  logic        o_valid, i_ready, i_redirect, o_misaligned;
  logic [31:0] o_opcode, o_pc, i_redirect_addr;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ack(i_imem_ack),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_valid(o_valid), .o_opcode(o_opcode), .o_pc(o_pc), .i_ready(i_ready),
    .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr), .o_misaligned(o_misaligned)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic rdy; logic req; logic [31:0] addr; logic vld; logic [31:0] pc; } vec_t;

  pend_t       pend[$];
  vec_t        vecs[6];
  int          n_chk = 0, n_pass = 0, cyc = 0, n_acks = 0, n_deliv = 0;
  int          ack_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] fpc, exp_pc, prev_addr;
  logic        prev_req, prev_ack, prev_redir;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) ^ NOP_INSN;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // One clock: sample at negedge, play memory and consumer, advance the reference model.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] raddr);
    @(negedge clk);
    cyc++;
    if (prev_redir) chk("valid_after_redirect", 32'(o_valid), 32'd0);
    if (prev_req && !prev_ack && !prev_redir) begin
      chk("req_hold", 32'(o_imem_req), 32'd1);
      chk("addr_hold", o_imem_addr, prev_addr);
    end
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'd0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = insn_of(pend[0].addr);
      pend.delete(0);
    end
    i_imem_ack = o_imem_req && (int'($urandom_range(99)) < ack_pct);
    if (i_imem_ack) begin
      chk("ack_addr", o_imem_addr, fpc);
      fpc += 32'd4;
      n_acks++;
      pend.push_back('{addr: o_imem_addr,
                       due: cyc + lat_min + int'($urandom_range(32'(lat_max - lat_min)))});
      chk("outstanding_le_depth", 32'(pend.size() <= DEPTH), 32'd1);
    end
    i_ready = rdy;
    i_redirect = redir;
    i_redirect_addr = raddr;
    if (o_valid && rdy && !redir) begin
      chk("deliv_pc", o_pc, exp_pc);
      chk("deliv_opcode", o_opcode, insn_of(exp_pc));
      exp_pc += 32'd4;
      n_deliv++;
    end
    if (redir) begin
      fpc = tgt(raddr);
      exp_pc = fpc;
    end
    prev_req = o_imem_req;
    prev_ack = i_imem_ack;
    prev_redir = redir;
    prev_addr = o_imem_addr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_req", 32'(o_imem_req), 32'd0);
    {i_imem_ack, i_imem_rvalid, i_ready, i_redirect} = 4'b0;
    i_imem_rdata = 32'd0;
    i_redirect_addr = 32'd0;
    pend.delete();
    @(negedge clk);
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_addr", o_imem_addr, RPC);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_opcode", o_opcode, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    rst_n = 1'b1;
    fpc = RPC;
    exp_pc = RPC;
    {prev_req, prev_ack, prev_redir} = 3'b0;
    prev_addr = 32'd0;
    n_acks = 0;
  endtask

  // Tick with the consumer ready until o_valid shows, then confirm the head PC.
  task automatic wait_valid(input logic [31:0] exp, input string nm);
    int n = 0;
    do begin
      tick(1'b1, 1'b0, 32'd0);
      n++;
    end while (!o_valid && n < 40);
    chk({nm, "_valid"}, 32'(o_valid), 32'd1);
    chk({nm, "_pc"}, o_pc, exp);
  endtask

  initial begin
    int start_deliv;
    vecs = '{'{1'b1, 1'b1, 32'd0,  1'b0, 32'd0},
             '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0},
             '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0},
             '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4},
             '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8},
             '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12}};
    rst_n = 1'b0;
    {i_imem_ack, i_imem_rvalid, i_ready, i_redirect} = 4'b0;
    i_imem_rdata = 32'd0;
    i_redirect_addr = 32'd0;

    // Streaming start-up: ack every cycle, one-cycle read latency.
    do_reset();
    foreach (vecs[i]) begin
      tick(vecs[i].rdy, 1'b0, 32'd0);
      chk("tbl_req", 32'(o_imem_req), 32'(vecs[i].req));
      chk("tbl_addr", o_imem_addr, vecs[i].addr);
      chk("tbl_valid", 32'(o_valid), 32'(vecs[i].vld));
      if (vecs[i].vld) chk("tbl_pc", o_pc, vecs[i].pc);
    end

    // Stalled consumer: requests stop at buffer depth, resume after one pop.
    do_reset();
    repeat (10) tick(1'b0, 1'b0, 32'd0);
    chk("stall_acks", 32'(n_acks), 32'(DEPTH));
    chk("stall_req_low", 32'(o_imem_req), 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("req_after_pop", 32'(o_imem_req), 32'd1);

    // Redirect with two requests in flight; both responses must be dropped.
    do_reset();
    lat_min = 3; lat_max = 3;
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 32'h100);
    wait_valid(32'h100, "redir_inflight");

    // Redirect in the same cycle as a pop and a read response.
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (5) tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 32'h200);
    chk("pop_rvalid_redir_valid", 32'(o_valid), 32'd1);
    wait_valid(32'h200, "redir_pop");

    // Fetch PC wraps from the top of the address space.
    tick(1'b1, 1'b1, 32'hFFFF_FFFC);
    wait_valid(32'hFFFF_FFFC, "wrap_top");
    wait_valid(32'h0000_0000, "wrap_zero");

    // Misaligned redirect target.
    tick(1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (8) begin
      tick(1'b1, 1'b0, 32'd0);
      chk("halt_misaligned", 32'(o_misaligned), 32'd1);
      chk("halt_req", 32'(o_imem_req), 32'd0);
      chk("halt_valid", 32'(o_valid), 32'd0);
    end
`else
    wait_valid(32'h100, "lsb_forced");
    chk("misaligned_tied", 32'(o_misaligned), 32'd0);
`endif

    // Random traffic with redirects and a mid-run reset.
    do_reset();
    ack_pct = 70; lat_min = 1; lat_max = 4;
    start_deliv = n_deliv;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ra;
      ra = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(3) * 4))
                                    : ($urandom & 32'hFFFF_FFFC);
      if (c == 1500) do_reset();
      tick($urandom_range(9) < 7, $urandom_range(39) == 0, ra);
    end
    chk("random_progress", 32'(n_deliv - start_deliv > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
